// File: rtl/register_writeback_queue_if.sv
// Write-request handshake and register-file write port of the writeback queue.
// slave is the queue side, master is the datapath/register-file side.
interface register_writeback_queue_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] addr_write;
    logic [DATA_W-1:0] data_write;
    logic              FLAG_register;

    modport slave (
        input  in_valid, in_addr, in_data,
        output in_ready, addr_write, data_write, FLAG_register
    );

    modport master (
        output in_valid, in_addr, in_data,
        input  in_ready, addr_write, data_write, FLAG_register
    );
endinterface

// File: rtl/register_writeback_queue.sv
// Buffers register-file writes in a small circular FIFO, drains one per cycle,
// and forwards the youngest pending write for the source/target operand lookups.
module register_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    register_writeback_queue_if.slave  bus,
    input  logic                       wb_hold,
    input  logic [ADDR_W-1:0]          query_src,
    input  logic [ADDR_W-1:0]          query_tgt,
    output logic                       fwd_src_hit,
    output logic [DATA_W-1:0]          fwd_src_data,
    output logic                       fwd_tgt_hit,
    output logic [DATA_W-1:0]          fwd_tgt_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_accept;
    logic w_push;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_pop    = !w_empty && !wb_hold;
    assign w_accept = bus.in_valid && bus.in_ready;
    // Writes to register 0 complete the handshake but are never queued.
    assign w_push   = w_accept && (bus.in_addr != '0);

    assign bus.in_ready      = !w_full || w_pop;
    assign bus.FLAG_register = w_pop;
    assign bus.addr_write    = w_empty ? '0 : r_mem_addr[r_rd_ptr];
    assign bus.data_write    = w_empty ? '0 : r_mem_data[r_rd_ptr];

    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= bus.in_addr;
            r_mem_data[r_wr_ptr] <= bus.in_data;
        end
    end

    // Walk from oldest to youngest so the last match seen is the youngest.
    function automatic logic [DATA_W:0] f_lookup(input logic [ADDR_W-1:0] q);
        logic [DATA_W:0] res;
        logic [PTR_W-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (q != '0) && (r_mem_addr[idx] == q))
                res = {1'b1, r_mem_data[idx]};
        end
        return res;
    endfunction

    always_comb begin
        fwd_src_hit  = 1'b0;
        fwd_src_data = '0;
        fwd_tgt_hit  = 1'b0;
        fwd_tgt_data = '0;
        {fwd_src_hit, fwd_src_data} = f_lookup(query_src);
        {fwd_tgt_hit, fwd_tgt_data} = f_lookup(query_tgt);
    end
endmodule

// File: tb/tb_register_writeback_queue.sv
// Directed bench for register_writeback_queue: expected writes go into a
// scoreboard queue, a separate monitor checks every register-file write.
module tb_register_writeback_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_hold = 1'b0;
    logic [4:0]  query_src = '0;
    logic [4:0]  query_tgt = '0;
    logic        fwd_src_hit, fwd_tgt_hit;
    logic [31:0] fwd_src_data, fwd_tgt_data;
    logic [2:0]  count;
    logic        empty, full;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] exp_q [$];

    register_writeback_queue_if #(.ADDR_W(5), .DATA_W(32)) bif ();

    register_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bif.slave),
        .wb_hold      (wb_hold),
        .query_src    (query_src),
        .query_tgt    (query_tgt),
        .fwd_src_hit  (fwd_src_hit),
        .fwd_src_data (fwd_src_data),
        .fwd_tgt_hit  (fwd_tgt_hit),
        .fwd_tgt_data (fwd_tgt_data),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        bif.in_valid = 1'b1;
        bif.in_addr  = a;
        bif.in_data  = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bif.in_ready === 1'b1) begin
                ok = 1'b1;
                if (a != 5'd0) exp_q.push_back({a, d});
            end
            tick();
        end
        bif.in_valid = 1'b0;
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && empty !== 1'b1; t++) tick();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_scoreboard_left", exp_q.size(), 32'd0);
    endtask

    // Monitor: every write-port strobe must match the oldest expected write.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bif.FLAG_register === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", 32'(bif.addr_write), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bif.addr_write), 32'(e[36:32]));
                    chk("wr_data", bif.data_write, e[31:0]);
                end
            end
        end
    end

    initial begin
        bif.in_valid = 1'b0;
        bif.in_addr  = '0;
        bif.in_data  = '0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_flag", 32'(bif.FLAG_register), 32'd0);
        chk("rst_addr_write", 32'(bif.addr_write), 32'd0);
        chk("rst_data_write", bif.data_write, 32'd0);
        chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
        chk("rst_fwd_src", {fwd_src_hit, fwd_src_data[30:0]}, 32'd0);
        chk("rst_fwd_tgt", {fwd_tgt_hit, fwd_tgt_data[30:0]}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single write latency
        push(5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("lat_flag", 32'(bif.FLAG_register), 32'd1);
        chk("lat_addr", 32'(bif.addr_write), 32'd5);
        chk("lat_data", bif.data_write, 32'hDEAD_BEEF);
        tick();
        chk("lat_empty_after", 32'(empty), 32'd1);
        chk("lat_flag_after", 32'(bif.FLAG_register), 32'd0);

        // Fill under hold, stalled fifth request, ordered drain
        wb_hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push(5'(k), 32'(k * 'h11));
            chk("fill_count", 32'(count), 32'(k));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(bif.in_ready), 32'd0);
        chk("fill_flag_held", 32'(bif.FLAG_register), 32'd0);
        chk("fill_head_addr", 32'(bif.addr_write), 32'd1);
        bif.in_valid = 1'b1;
        bif.in_addr  = 5'd5;
        bif.in_data  = 32'h55;
        @(negedge clk);
        chk("stall_in_ready", 32'(bif.in_ready), 32'd0);
        tick();
        chk("stall_count", 32'(count), 32'd4);
        wb_hold = 1'b0;
        @(negedge clk);
        chk("release_in_ready", 32'(bif.in_ready), 32'd1);
        exp_q.push_back({5'd5, 32'h55});
        tick();
        bif.in_valid = 1'b0;
        chk("release_count", 32'(count), 32'd4);
        wait_drain();

        // Forwarding: youngest match wins, head included
        wb_hold = 1'b1;
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        push(5'd3, 32'hC);
        query_src = 5'd7;
        query_tgt = 5'd8;
        #1;
        chk("fwd_src_hit", 32'(fwd_src_hit), 32'd1);
        chk("fwd_src_data", fwd_src_data, 32'hB);
        chk("fwd_tgt_miss_hit", 32'(fwd_tgt_hit), 32'd0);
        chk("fwd_tgt_miss_data", fwd_tgt_data, 32'd0);
        query_tgt = 5'd3;
        #1;
        chk("fwd_tgt_hit", 32'(fwd_tgt_hit), 32'd1);
        chk("fwd_tgt_data", fwd_tgt_data, 32'hC);
        chk("hold_head_addr", 32'(bif.addr_write), 32'd7);
        chk("hold_head_data", bif.data_write, 32'hA);
        wb_hold = 1'b0;
        wait_drain();
        chk("fwd_after_drain", 32'(fwd_src_hit), 32'd0);

        // Register 0 writes are swallowed
        push(5'd0, 32'hFFFF_FFFF);
        chk("zero_count", 32'(count), 32'd0);
        chk("zero_empty", 32'(empty), 32'd1);
        query_src = 5'd0;
        #1;
        chk("zero_fwd_hit", 32'(fwd_src_hit), 32'd0);
        chk("zero_fwd_data", fwd_src_data, 32'd0);
        repeat (3) tick();

        // Full streaming across pointer wrap
        wb_hold = 1'b1;
        for (int k = 0; k < 4; k++) push(5'(9 + k), 32'h100 + 32'(k));
        wb_hold = 1'b0;
        for (int k = 0; k < 12; k++) begin
            push(5'((k % 30) + 1), 32'hC000 + 32'(k));
            chk("stream_count", 32'(count), 32'd4);
        end
        wait_drain();

        // Asynchronous reset mid-operation discards pending writes
        wb_hold = 1'b1;
        push(5'd20, 32'h20);
        push(5'd21, 32'h21);
        push(5'd22, 32'h22);
        wb_hold = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_flag", 32'(bif.FLAG_register), 32'd0);
        chk("arst_addr_write", 32'(bif.addr_write), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_empty", 32'(empty), 32'd1);
        push(5'd25, 32'h77);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/register_writeback_queue.md
Name: register_writeback_queue

Overview:
- Writer-side front end for the 32x32 register file.
- Accepts register-write requests from the datapath over a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle onto the register file write port (addr_write / data_write / FLAG_register).
- Provides youngest-match forwarding of still-pending writes, so source/target reads never return stale data.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  write request present
in_ready  output  1  queue can accept the request this cycle
in_addr  input  ADDR_W  destination register of the request
in_data  input  DATA_W  data of the request
wb_hold  input  1  write port borrowed elsewhere; suppress drain this cycle
addr_write  output  ADDR_W  register file write address (head entry)
data_write  output  DATA_W  register file write data (head entry)
FLAG_register  output  1  register file write enable
query_src  input  ADDR_W  forwarding lookup address, source operand
query_tgt  input  ADDR_W  forwarding lookup address, target operand
fwd_src_hit  output  1  pending write to query_src exists
fwd_src_data  output  DATA_W  data of youngest pending write to query_src
fwd_tgt_hit  output  1  pending write to query_tgt exists
fwd_tgt_data  output  DATA_W  data of youngest pending write to query_tgt
count  output  $clog2(DEPTH)+1  occupied entries
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- Interface is decided: one clock, clk; reset rst_n is asynchronous and active-low. rst_n low clears pointers and count immediately, independent of clk.
- Reset values: count=0, empty=1, full=0, FLAG_register=0, addr_write=0, data_write=0, fwd_*_hit=0, fwd_*_data=0, in_ready=1.
- Storage: circular buffer, write pointer and read pointer each wrap modulo DEPTH. Entry contents need no reset.
- Drain (combinational from state): FLAG_register = !empty && !wb_hold.
  - addr_write and data_write show the head entry when !empty, else 0.
  - At a posedge with FLAG_register=1 the head pops; the register file captures the write on that same edge.
- Accept: in_ready = !full || FLAG_register. A push occurs at a posedge with in_valid && in_ready.
- Push with in_addr==0: handshake completes, nothing is stored, count unchanged. Register 0 is never written.
- Simultaneous push and pop: both happen; count unchanged. Legal even when full, because pop frees the slot on the same edge.
- Latency: an entry pushed at edge N is visible on the write port during cycle N+1 if the queue was empty and wb_hold=0. It is written at edge N+1.
- A request is never bypassed straight to the write port in the same cycle it arrives.
- Order: writes reach the register file strictly in acceptance order, including repeated writes to the same address.
- wb_hold while non-empty: head held stable, no pop; pushes continue until full.
- Forwarding: combinational search of all occupied entries, head included (not yet written).
  - The youngest matching entry wins; hit=1 and data = that entry's data.
  - No match, or query address 0: hit=0, data=0.
  - The incoming in_* request is not searched.
- in_valid while !in_ready: no push. Sender must hold in_addr and in_data stable until accepted.
- Reset asserted mid-operation: all pending writes are discarded. FLAG_register falls to 0 asynchronously.
- Counter arithmetic: count ranges 0..DEPTH with no overflow. A push when full without a pop is impossible by construction.

Test Plan:
- Reset, then push (addr 5, 0xDEADBEEF) with wb_hold=0 -> next cycle FLAG_register=1, addr_write=5, data_write=0xDEADBEEF; following cycle empty=1, FLAG_register=0.
- wb_hold=1, push 4 entries (addr 1..4, data 0x11..0x44) -> full=1, in_ready=0, count=4; 5th request stalls. Release hold -> writes drain in order 1,2,3,4 on consecutive edges, and the stalled request is accepted on the first drain edge.
- wb_hold=1, push (7, 0xA), then (7, 0xB); query_src=7 -> fwd_src_hit=1, fwd_src_data=0xB. Set query_tgt=8 -> fwd_tgt_hit=0, fwd_tgt_data=0.
- Push (0, 0xFFFFFFFF) -> in_ready=1, count stays 0, FLAG_register never asserts. query_src=0 -> hit=0.
- Full queue, wb_hold=0, continuous in_valid -> push and pop on every edge, count stays 4, output order matches input order across pointer wrap (at least 10 entries).
- With 3 pending entries, drop rst_n between edges -> count=0, empty=1, FLAG_register=0 immediately. After release, no old entry appears on the write port.
